// File: rtl/lfsr_word_sampler.sv
// Samples a free-running whitening LFSR once every SPACING clocks after a post-reset
// warm-up, buffering the words in a 2-entry FIFO behind a valid/ready handshake.
module lfsr_word_sampler #(
    parameter int WIDTH   = 16,
    parameter int SPACING = 16,
    parameter int WARMUP  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] lfsr,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       drop_count
);

    localparam int DEPTH = 2;
    localparam int SP_W  = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam int WU_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(SPACING - 1);
    localparam logic [WU_W-1:0] WU_DONE = WU_W'(WARMUP);

    logic [WU_W-1:0]  warm_cnt_reg;
    logic [SP_W-1:0]  sp_reg;
    logic [1:0]       occ_reg;
    logic [1:0]       occ_next;
    logic [7:0]       drop_reg;
    logic [WIDTH-1:0] entry_reg  [DEPTH];
    logic [WIDTH-1:0] entry_next [DEPTH];

    logic       warm_done;
    logic       capture;
    logic       pop;
    logic       accept;
    logic [1:0] base;

    assign warm_done = (warm_cnt_reg == WU_DONE);
    assign capture   = warm_done && enable && (sp_reg == SP_LAST);
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes the new word when the head leaves on the same edge.
    assign accept    = capture && ((occ_reg != 2'd2) || pop);
    assign base      = pop ? (occ_reg - 2'd1) : occ_reg;
    assign occ_next  = occ_reg + {1'b0, accept} - {1'b0, pop};

    assign out_word   = entry_reg[0];
    assign out_valid  = (occ_reg != 2'd0);
    assign drop_count = drop_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_reg <= '0;
            sp_reg       <= '0;
        end else if (!warm_done) begin
            warm_cnt_reg <= warm_cnt_reg + WU_W'(1);
            sp_reg       <= '0;
        end else if (!enable) begin
            sp_reg <= '0;
        end else begin
            sp_reg <= (sp_reg == SP_LAST) ? '0 : sp_reg + SP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg  <= 2'd0;
            drop_reg <= 8'd0;
        end else begin
            occ_reg <= occ_next;
            if (capture && !accept && (drop_reg != 8'hFF))
                drop_reg <= drop_reg + 8'd1;
        end
    end

    // Entry 0 is always the head; a pop shifts everything down one slot and
    // the new word lands just behind whatever remains.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] shifted;
            if (gi == DEPTH - 1) begin : g_last
                assign shifted = entry_reg[gi];
            end else begin : g_mid
                assign shifted = entry_reg[gi + 1];
            end

            assign entry_next[gi] = (accept && (base == 2'(gi))) ? lfsr
                                  : (pop ? shifted : entry_reg[gi]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    entry_reg[gi] <= '0;
                else
                    entry_reg[gi] <= entry_next[gi];
            end
        end
    endgenerate

endmodule

// File: tb/tb_lfsr_word_sampler.sv
// Directed bench for lfsr_word_sampler: lfsr carries the edge index since reset
// release, so each captured word names the edge that captured it.
module tb_lfsr_word_sampler;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             enable = 1'b1;
    logic [WIDTH-1:0] lfsr = '0;
    logic [WIDTH-1:0] out_word;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    lfsr_word_sampler #(.WIDTH(WIDTH), .SPACING(16), .WARMUP(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .lfsr       (lfsr),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge; cyc is the
    // index of the next rising edge, so after a tick we see the state after edge cyc-1.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        lfsr = WIDTH'(cyc);
    endtask

    task automatic after_edge(input int e);
        while (cyc < e + 1) tick();
    endtask

    task automatic count_valid(input int from, input int to, output int n);
        n = 0;
        for (int e = from; e <= to; e++) begin
            after_edge(e);
            if (out_valid) n++;
        end
    endtask

    // Outputs must clear 1 ns into reset, well before the next rising edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_drop"},  32'(drop_count), 32'd0);
        check_eq({tag, "_word"},  32'(out_word), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        lfsr  = '0;
    endtask

    initial begin
        int n;
        int n2;

        // Streaming with the consumer always ready
        enable = 1'b1; out_ready = 1'b1;
        do_reset("rst0");
        count_valid(0, 46, n);
        check_eq("warmup_quiet", 32'(n), 32'd0);
        after_edge(47);
        check_eq("cap47_valid", 32'(out_valid), 32'd1);
        check_eq("cap47_word",  32'(out_word), 32'd47);
        after_edge(48);
        check_eq("pulse_end", 32'(out_valid), 32'd0);
        after_edge(63);
        check_eq("cap63_word", 32'(out_word), 32'd63);
        after_edge(79);
        check_eq("cap79_word", 32'(out_word), 32'd79);
        check_eq("stream_drop", 32'(drop_count), 32'd0);

        // Consumer stalled for five capture periods
        out_ready = 1'b0;
        do_reset("rst1");
        after_edge(63);
        check_eq("full_word", 32'(out_word), 32'd47);
        after_edge(111);
        check_eq("stall_drop", 32'(drop_count), 32'd3);
        check_eq("stall_word", 32'(out_word), 32'd47);
        out_ready = 1'b1;
        after_edge(112);
        check_eq("drain1_word",  32'(out_word), 32'd63);
        check_eq("drain1_valid", 32'(out_valid), 32'd1);
        after_edge(113);
        check_eq("drain2_valid", 32'(out_valid), 32'd0);
        check_eq("drain_drop",   32'(drop_count), 32'd3);

        // Pop coinciding with a capture into a full FIFO
        out_ready = 1'b0;
        do_reset("rst2");
        after_edge(78);
        out_ready = 1'b1;
        after_edge(79);
        out_ready = 1'b0;
        check_eq("coinc_word",  32'(out_word), 32'd63);
        check_eq("coinc_drop",  32'(drop_count), 32'd0);
        out_ready = 1'b1;
        after_edge(80);
        check_eq("coinc_next",  32'(out_word), 32'd79);
        check_eq("coinc_valid", 32'(out_valid), 32'd1);
        after_edge(81);
        check_eq("coinc_empty", 32'(out_valid), 32'd0);

        // enable low for three edges while sp is 10
        out_ready = 1'b1; enable = 1'b1;
        do_reset("rst3");
        after_edge(41);
        enable = 1'b0;
        count_valid(42, 44, n);
        enable = 1'b1;
        count_valid(45, 59, n2);
        check_eq("en_gap_quiet", 32'(n + n2), 32'd0);
        after_edge(60);
        check_eq("en_cap_valid", 32'(out_valid), 32'd1);
        check_eq("en_cap_word",  32'(out_word), 32'd60);
        after_edge(76);
        check_eq("en_cap2_word", 32'(out_word), 32'd76);

        // Asynchronous reset with two words buffered and three drops
        out_ready = 1'b0;
        do_reset("rst4");
        after_edge(111);
        check_eq("pre_rst_drop",  32'(drop_count), 32'd3);
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        do_reset("rst_async");
        count_valid(0, 46, n);
        check_eq("rewarm_quiet", 32'(n), 32'd0);
        after_edge(47);
        check_eq("rewarm_word",  32'(out_word), 32'd47);
        check_eq("rewarm_valid", 32'(out_valid), 32'd1);

        // Long stall: drop counter saturates
        out_ready = 1'b0;
        do_reset("rst5");
        after_edge(47 + 16 * 255);
        check_eq("sat_254", 32'(drop_count), 32'd254);
        after_edge(47 + 16 * 256);
        check_eq("sat_255", 32'(drop_count), 32'd255);
        after_edge(47 + 16 * 299);
        check_eq("sat_hold", 32'(drop_count), 32'd255);
        check_eq("sat_word", 32'(out_word), 32'd47);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
